clken_pll_gen: RTL and testbench
================================

Name: clken_pll_gen

Overview:
- Parametrised successor to the single-output fixed-ratio clock block: generates NUM_CH independent fractional clock-enable streams from one reference clock.
- Each channel is a phase accumulator (DDS-style) with run-time programmable increment and phase. Each channel gives a one-cycle enable pulse and a toggled ~50% square output.
- Provides a lock/settle indicator equivalent to a PLL `locked`, which re-arms on every reconfiguration.
- Sits between the board reference clock and the coprocessor datapath; downstream logic runs on refclk, gated by `clken`.

Parameters:
- NUM_CH, 4, number of output channels (1..16).
- ACC_W, 16, phase-accumulator width in bits (8..32).
- DEFAULT_INCR, 16'h8000, increment loaded into every channel at reset (zero-extended or truncated to ACC_W).
- LOCK_CYCLES, 16, refclk cycles from reset release or last config write until `locked` rises (>=1).
- CH_W, $clog2(NUM_CH) (min 1), channel index width (derived).

Ports:
- refclk  in  1  sole clock, rising edge.
- rst  in  1  asynchronous reset, active-low (asserted at 0).
- cfg_we  in  1  config write strobe, one cycle.
- cfg_ch  in  CH_W  channel to configure.
- cfg_incr  in  ACC_W  new increment; 0 disables the channel.
- cfg_phase  in  ACC_W  accumulator preload value.
- clken  out  NUM_CH  per-channel one-cycle enable pulse.
- outclk  out  NUM_CH  per-channel toggle output, flips on each `clken` pulse.
- locked  out  1  all channels settled since the last reset/config.

Behaviour:
- Reset (rst=0, async): acc[i]=0, incr[i]=DEFAULT_INCR, clken=0, outclk=0, settle counter=0, locked=0.
- Every edge, per channel i: {carry, acc[i]} <= acc[i] + incr[i] (ACC_W+1-bit sum). clken[i] <= carry. If carry=1, outclk[i] <= ~outclk[i].
- All outputs are registered. clken[i] is high during the cycle following the edge on which the accumulator wrapped.
- Average rate is f_refclk * incr / 2^ACC_W. The pulse spacing per channel is floor or ceil of 2^ACC_W/incr.
- incr=0: the accumulator holds, clken[i] stays 0 and outclk[i] holds its value.
- Config write (cfg_we=1, cfg_ch<NUM_CH) on an edge:
  - acc[ch] <= cfg_phase and incr[ch] <= cfg_incr.
  - clken[ch] <= 0 for that edge; the write wins over a simultaneous carry.
  - outclk[ch] is unchanged.
  - The settle counter clears to 0 and locked <= 0 on the same edge.
- Config write with cfg_ch >= NUM_CH: ignored entirely. Accumulators, settle counter and locked are unaffected.
- Settle counter: increments each edge while below LOCK_CYCLES and saturates there. locked <= 1 on the edge where the counter reaches LOCK_CYCLES. locked rises on the LOCK_CYCLES-th edge after reset release or after the last valid write.
- Back-to-back writes keep locked low; each one restarts the count.
- Other channels are unaffected by a write and continue pulsing during the settle period.
- Reset asserted mid-operation: all state returns to reset values immediately (async). Recovery is synchronous from the first edge after rst returns to 1.
- No state machine beyond the per-channel accumulators and the settle counter. The settle logic has two implicit states, SETTLING and LOCKED.

Decomposition:
- Shared package `clk_gen_pkg` holds:
  - the default ACC_W/LOCK_CYCLES constants;
  - a `cfg_req_t` struct {we, ch, incr, phase} for upstream config masters.
- One natural sub-module, `clken_phase_acc`: a single-channel accumulator with write port, clken and outclk outputs. It is instantiated NUM_CH times via generate.
- The settle counter and write decode stay in the top module.

Test Plan:
- Defaults (ACC_W=16, DEFAULT_INCR=0x8000), release reset -> clken[i] high on edges 2,4,6,…; outclk toggles at the same edges (period 4 cycles); locked=1 from edge 16.
- Write ch1 incr=0x6000, phase=0 -> ch1 clken at edges 3,6,8 after the write, repeating every 8; locked drops on the write edge and returns 16 edges later; ch0 pattern undisturbed.
- Write ch2 incr=0 -> clken[2]=0 indefinitely and outclk[2] frozen. Then write incr=0x4000, phase=0xC000 -> first clken[2] on the 1st edge after the write, then every 4.
- Write cfg_ch=5 with NUM_CH=4 -> no output change; locked stays 1.
- Write on the exact edge ch0 would carry -> no clken[0] pulse that cycle; accumulator equals cfg_phase next cycle.
- Assert rst=0 asynchronously mid-stream -> clken, outclk and locked go to 0 without waiting for a clock edge. After release, the sequence restarts as in the defaults case.

Source files
------------

// File: rtl/clk_gen_pkg.sv
// Shared constants and config-request type for the clock-enable generator family.
// Latency: n/a (types and constants only).
// Backpressure: n/a; config requests are fire-and-forget single-cycle strobes.
package clk_gen_pkg;

    localparam int ACC_W_DEF       = 16;
    localparam int LOCK_CYCLES_DEF = 16;
    localparam int CH_W_DEF        = 2;

    typedef struct packed {
        logic                 we;
        logic [CH_W_DEF-1:0]  ch;
        logic [ACC_W_DEF-1:0] incr;
        logic [ACC_W_DEF-1:0] phase;
    } cfg_req_t;

endpackage

// File: rtl/clken_phase_acc.sv
// Single-channel DDS phase accumulator producing a wrap pulse and a toggled square output.
// Latency: clken/outclk registered, valid the cycle after the accumulator wraps.
// Backpressure: none; a write reloads phase/increment and suppresses that edge's pulse.
module clken_phase_acc #(
    parameter int               ACC_W        = 16,
    parameter logic [ACC_W-1:0] DEFAULT_INCR = '0
) (
    input  logic             refclk,
    input  logic             rst,
    input  logic             wr_en,
    input  logic [ACC_W-1:0] wr_incr,
    input  logic [ACC_W-1:0] wr_phase,
    output logic             clken,
    output logic             outclk
);

    logic [ACC_W-1:0] acc;
    logic [ACC_W-1:0] incr;
    logic [ACC_W:0]   sum;

    assign sum = {1'b0, acc} + {1'b0, incr};

    always_ff @(posedge refclk or negedge rst) begin
        if (!rst) begin
            acc    <= '0;
            incr   <= DEFAULT_INCR;
            clken  <= 1'b0;
            outclk <= 1'b0;
        end else if (wr_en) begin
            // Reload takes priority over a carry on the same edge; outclk keeps its level.
            acc   <= wr_phase;
            incr  <= wr_incr;
            clken <= 1'b0;
        end else begin
            acc   <= sum[ACC_W-1:0];
            clken <= sum[ACC_W];
            if (sum[ACC_W]) begin
                outclk <= ~outclk;
            end
        end
    end

endmodule

// File: rtl/clken_pll_gen.sv
// NUM_CH independent fractional clock-enable streams with a PLL-style settle indicator.
// Latency: all outputs registered; locked rises LOCK_CYCLES edges after reset or last valid write.
// Backpressure: none; writes to channels >= NUM_CH are dropped without side effects.
module clken_pll_gen
    import clk_gen_pkg::*;
#(
    parameter int          NUM_CH       = 4,
    parameter int          ACC_W        = ACC_W_DEF,
    parameter logic [31:0] DEFAULT_INCR = 32'h0000_8000,
    parameter int          LOCK_CYCLES  = LOCK_CYCLES_DEF,
    parameter int          CH_W         = (NUM_CH > 1) ? $clog2(NUM_CH) : 1
) (
    input  logic              refclk,
    input  logic              rst,
    input  logic              cfg_we,
    input  logic [CH_W-1:0]   cfg_ch,
    input  logic [ACC_W-1:0]  cfg_incr,
    input  logic [ACC_W-1:0]  cfg_phase,
    output logic [NUM_CH-1:0] clken,
    output logic [NUM_CH-1:0] outclk,
    output logic              locked
);

    localparam int               CNT_W     = $clog2(LOCK_CYCLES + 1);
    localparam logic [CNT_W-1:0] LOCK_LIM  = CNT_W'(LOCK_CYCLES);
    localparam logic [CH_W:0]    NUM_CH_L  = (CH_W + 1)'(NUM_CH);
    localparam logic [ACC_W-1:0] INCR_INIT = ACC_W'(DEFAULT_INCR);

    logic             wr_valid;
    logic [CNT_W-1:0] settle_cnt;

    assign wr_valid = cfg_we && ({1'b0, cfg_ch} < NUM_CH_L);

    // Settle counter saturates at LOCK_LIM; locked is set on the edge it gets there.
    always_ff @(posedge refclk or negedge rst) begin
        if (!rst) begin
            settle_cnt <= '0;
            locked     <= 1'b0;
        end else if (wr_valid) begin
            settle_cnt <= '0;
            locked     <= 1'b0;
        end else if (settle_cnt != LOCK_LIM) begin
            settle_cnt <= settle_cnt + 1'b1;
            locked     <= (settle_cnt == LOCK_LIM - 1'b1);
        end
    end

    for (genvar i = 0; i < NUM_CH; i++) begin : g_ch
        clken_phase_acc #(
            .ACC_W        (ACC_W),
            .DEFAULT_INCR (INCR_INIT)
        ) u_acc (
            .refclk   (refclk),
            .rst      (rst),
            .wr_en    (wr_valid && (cfg_ch == CH_W'(i))),
            .wr_incr  (cfg_incr),
            .wr_phase (cfg_phase),
            .clken    (clken[i]),
            .outclk   (outclk[i])
        );
    end

endmodule

// File: tb/tb_clken_pll_gen.sv
// Self-checking bench: closed-form wrap-count model of every channel plus literal pins.
module tb_clken_pll_gen;

    localparam int NCH  = 3;
    localparam int W    = 16;
    localparam int LOCK = 16;

    logic           refclk = 1'b0;
    logic           rst;
    logic           cfg_we;
    logic [1:0]     cfg_ch;
    logic [W-1:0]   cfg_incr;
    logic [W-1:0]   cfg_phase;
    logic [NCH-1:0] clken;
    logic [NCH-1:0] outclk;
    logic           locked;

    int n_tests = 0;
    int n_fail  = 0;
    bit chk_en  = 1'b0;

    // Model: a channel's pulse count after k edges since load is floor((p + k*incr) / 2^W).
    longint unsigned m_phase [NCH];
    longint unsigned m_incr  [NCH];
    longint unsigned m_k     [NCH];
    int              m_pulses[NCH];
    logic [NCH-1:0]  m_clken;
    int              m_since;
    int              ecount;

    always #5 refclk = ~refclk;

    clken_pll_gen #(
        .NUM_CH       (NCH),
        .ACC_W        (W),
        .DEFAULT_INCR (32'h0000_8000),
        .LOCK_CYCLES  (LOCK)
    ) dut (
        .refclk    (refclk),
        .rst       (rst),
        .cfg_we    (cfg_we),
        .cfg_ch    (cfg_ch),
        .cfg_incr  (cfg_incr),
        .cfg_phase (cfg_phase),
        .clken     (clken),
        .outclk    (outclk),
        .locked    (locked)
    );

    function automatic longint unsigned wraps(longint unsigned p, longint unsigned inc,
                                              longint unsigned k);
        return (p + k * inc) >> W;
    endfunction

    task automatic check(string name, logic [31:0] act, logic [31:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h at t=%0t", name, act, exp, $time);
        end
    endtask

    initial begin
        forever begin
            @(posedge refclk or negedge rst);
            if (!rst) begin
                for (int c = 0; c < NCH; c++) begin
                    m_phase[c]  = 0;
                    m_incr[c]   = 64'h8000;
                    m_k[c]      = 0;
                    m_pulses[c] = 0;
                end
                m_clken = '0;
                m_since = 0;
                ecount  = 0;
            end else begin
                ecount++;
                for (int c = 0; c < NCH; c++) begin
                    if (cfg_we && int'(cfg_ch) < NCH && int'(cfg_ch) == c) begin
                        m_phase[c] = cfg_phase;
                        m_incr[c]  = cfg_incr;
                        m_k[c]     = 0;
                        m_clken[c] = 1'b0;
                    end else begin
                        m_k[c]++;
                        m_clken[c] = wraps(m_phase[c], m_incr[c], m_k[c]) !=
                                     wraps(m_phase[c], m_incr[c], m_k[c] - 1);
                        if (m_clken[c]) m_pulses[c]++;
                    end
                end
                if (cfg_we && int'(cfg_ch) < NCH) m_since = 0;
                else if (m_since < LOCK) m_since++;
            end
        end
    end

    initial begin
        logic [NCH-1:0] exp_out;
        forever begin
            @(negedge refclk);
            if (chk_en) begin
                for (int c = 0; c < NCH; c++) exp_out[c] = m_pulses[c][0];
                check("model_clken", 32'(clken), 32'(m_clken));
                check("model_outclk", 32'(outclk), 32'(exp_out));
                check("model_locked", 32'(locked), 32'(m_since >= LOCK));
            end
        end
    end

    task automatic cfg_write(logic [1:0] ch, logic [W-1:0] inc, logic [W-1:0] ph);
        cfg_we    = 1'b1;
        cfg_ch    = ch;
        cfg_incr  = inc;
        cfg_phase = ph;
        @(negedge refclk);
        cfg_we = 1'b0;
    endtask

    task automatic default_sequence(string tag);
        for (int e = 1; e <= 18; e++) begin
            @(negedge refclk);
            check({tag, "_clken"}, 32'(clken), (e % 2 == 0) ? 32'h7 : 32'h0);
            check({tag, "_outclk"}, 32'(outclk), ((e / 2) % 2 == 1) ? 32'h7 : 32'h0);
            check({tag, "_locked"}, 32'(locked), 32'(e >= 16));
        end
    endtask

    initial begin
        rst       = 1'b0;
        cfg_we    = 1'b0;
        cfg_ch    = '0;
        cfg_incr  = '0;
        cfg_phase = '0;
        repeat (3) @(negedge refclk);
        check("rst_clken", 32'(clken), 32'h0);
        check("rst_outclk", 32'(outclk), 32'h0);
        check("rst_locked", 32'(locked), 32'h0);
        chk_en = 1'b1;
        rst    = 1'b1;
        default_sequence("def");

        cfg_write(2'd1, 16'h6000, 16'h0000);
        check("wr_locked_drop", 32'(locked), 32'h0);
        for (int j = 1; j <= 8; j++) begin
            @(negedge refclk);
            check("ch1_clken", 32'(clken[1]), 32'(j == 3 || j == 6 || j == 8));
        end
        repeat (7) @(negedge refclk);
        check("relock_early", 32'(locked), 32'h0);
        @(negedge refclk);
        check("relock", 32'(locked), 32'h1);

        cfg_write(2'd2, 16'h0000, 16'h0000);
        for (int j = 0; j < 12; j++) begin
            @(negedge refclk);
            check("ch2_off_clken", 32'(clken[2]), 32'h0);
        end
        cfg_write(2'd2, 16'h4000, 16'hC000);
        for (int j = 1; j <= 9; j++) begin
            @(negedge refclk);
            check("ch2_phase_clken", 32'(clken[2]), 32'(j % 4 == 1));
        end
        repeat (20) @(negedge refclk);
        check("locked_before_bad", 32'(locked), 32'h1);

        cfg_write(2'd3, 16'h0000, 16'h1111);
        check("bad_ch_locked", 32'(locked), 32'h1);
        repeat (4) @(negedge refclk);

        // Ch0 still runs at 0x8000 from reset, so it carries on even edge numbers.
        if (ecount % 2 == 0) @(negedge refclk);
        cfg_write(2'd0, 16'h8000, 16'h1234);
        check("carry_wr_clken", 32'(clken[0]), 32'h0);
        @(negedge refclk);
        check("after_wr_clken1", 32'(clken[0]), 32'h0);
        @(negedge refclk);
        check("after_wr_clken2", 32'(clken[0]), 32'h1);

        for (int r = 0; r < 400; r++) begin
            if ($urandom_range(7) == 0) begin
                int mode;
                mode      = $urandom_range(3);
                cfg_we    = 1'b1;
                cfg_ch    = 2'($urandom_range(3));
                cfg_incr  = (mode == 0) ? 16'h0 :
                            (mode == 1) ? 16'($urandom_range(255, 1)) : 16'($urandom);
                cfg_phase = 16'($urandom);
            end else begin
                cfg_we = 1'b0;
            end
            @(negedge refclk);
        end
        cfg_we = 1'b0;
        cfg_write(2'd0, 16'h2AAB, 16'h0);
        cfg_write(2'd1, 16'h7001, 16'h0);
        repeat (24) @(negedge refclk);

        @(posedge refclk);
        #2 rst = 1'b0;
        #1;
        check("async_clken", 32'(clken), 32'h0);
        check("async_outclk", 32'(outclk), 32'h0);
        check("async_locked", 32'(locked), 32'h0);
        @(negedge refclk);
        rst = 1'b1;
        default_sequence("rerun");

        chk_en = 1'b0;
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
